// File: rtl/phy_lane_striper.sv
// Round-robin lane striper: spreads valid words over the active lanes, diverts
// words to the recirculation output when no lane is active, and counts per-lane traffic.
module phy_lane_striper #(
    parameter  int LANES  = 2,
    parameter  int WORD_W = 32,
    parameter  int CNT_W  = 16,
    localparam int PTR_W  = $clog2(LANES)
) (
    input  logic                    clk_f,
    input  logic                    reset_L,
    input  logic [LANES-1:0]        active_lane,
    input  logic                    valid_in,
    input  logic [WORD_W-1:0]       data_in,
    output logic [LANES*WORD_W-1:0] data_out,
    output logic [LANES-1:0]        valid_out,
    output logic [WORD_W-1:0]       data_out_Recirc_Retorno,
    output logic                    valid_recirc,
    output logic [PTR_W-1:0]        lane_ptr,
    output logic [LANES*CNT_W-1:0]  word_count
);

    logic [LANES-1:0][WORD_W-1:0] lane_data_r;
    logic [LANES-1:0][CNT_W-1:0]  count_r;
    logic [LANES-1:0]             valid_out_r;
    logic [WORD_W-1:0]            recirc_data_r;
    logic                         valid_recirc_r;
    logic [PTR_W-1:0]             lane_ptr_r;

    logic                         any_active_s;
    logic [PTR_W-1:0]             target_s;
    logic [PTR_W-1:0]             next_ptr_s;
    logic                         count_sat_s;

    // Lane index successor, wrapping at LANES (which need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        logic [PTR_W-1:0] res;
        if (int'(idx) == LANES - 1) begin
            res = {PTR_W{1'b0}};
        end else begin
            res = idx + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // First set mask bit at or after start, searching cyclically; start if none set.
    function automatic logic [PTR_W-1:0] first_set_from(input logic [LANES-1:0] mask,
                                                        input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] res;
        logic             found;
        idx   = start;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return res;
    endfunction

    // Lane selection and pointer advance from the same-cycle mask.
    always_comb begin
        any_active_s = |active_lane;
        target_s     = first_set_from(active_lane, lane_ptr_r);
        // Searching from t+1 over all lanes returns t itself when it is the only active lane.
        next_ptr_s   = first_set_from(active_lane, wrap_inc(target_s));
        count_sat_s  = (count_r[target_s] == {CNT_W{1'b1}});
    end

    // Datapath, pulses, pointer and counters; synchronous active-low reset.
    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            lane_data_r    <= {(LANES*WORD_W){1'b0}};
            count_r        <= {(LANES*CNT_W){1'b0}};
            valid_out_r    <= {LANES{1'b0}};
            recirc_data_r  <= {WORD_W{1'b0}};
            valid_recirc_r <= 1'b0;
            lane_ptr_r     <= {PTR_W{1'b0}};
        end else begin
            valid_out_r    <= {LANES{1'b0}};
            valid_recirc_r <= 1'b0;
            if (valid_in && any_active_s) begin
                lane_data_r[target_s] <= data_in;
                valid_out_r[target_s] <= 1'b1;
                lane_ptr_r            <= next_ptr_s;
                if (!count_sat_s) begin
                    count_r[target_s] <= count_r[target_s] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    count_r[target_s] <= count_r[target_s];
                end
            end else if (valid_in) begin
                recirc_data_r  <= data_in;
                valid_recirc_r <= 1'b1;
            end else begin
                lane_ptr_r <= lane_ptr_r;
            end
        end
    end

    assign data_out                = lane_data_r;
    assign valid_out               = valid_out_r;
    assign data_out_Recirc_Retorno = recirc_data_r;
    assign valid_recirc            = valid_recirc_r;
    assign lane_ptr                = lane_ptr_r;
    assign word_count              = count_r;

endmodule

// File: doc/phy_lane_striper.md
# phy_lane_striper

Parametrised single-clock lane striper for the PHY transmit path. It distributes a stream of valid-qualified words round-robin across `LANES` output lanes and skips lanes whose `active_lane` bit is low. Words arriving while no lane is active go to the recirculation/return output. Per-lane word counters give the verification bench and the link-status logic visibility into traffic. It generalises the fixed two-lane transmit split to N lanes and arbitrary word width, and adds runtime lane masking, recirculation and saturating counters.

## Interface
Parameters:
- `LANES`, default 2: number of output lanes; legal range 2..8.
- `WORD_W`, default 32: word width in bits.
- `CNT_W`, default 16: width of each per-lane word counter.
- `PTR_W`, derived as `$clog2(LANES)`, not overridable: lane-pointer width.

Ports:
- `clk_f`  in  1: the only clock; all state updates on its rising edge.
- `reset_L`  in  1: reset, synchronous and active-low.
- `active_lane`  in  LANES: bit i set means lane i may receive words; sampled every cycle.
- `valid_in`  in  1: `data_in` holds a word this cycle.
- `data_in`  in  WORD_W: input word.
- `data_out`  out  LANES*WORD_W: lane i occupies bits [i*WORD_W +: WORD_W]; registered.
- `valid_out`  out  LANES: one-cycle pulse per lane when that lane's slice is updated.
- `data_out_Recirc_Retorno`  out  WORD_W: word diverted because no lane was active; registered.
- `valid_recirc`  out  1: one-cycle pulse accompanying a recirculated word.
- `lane_ptr`  out  PTR_W: index of the next preferred lane.
- `word_count`  out  LANES*CNT_W: lane i counter occupies [i*CNT_W +: CNT_W].

## Operation
- **Reset.** When `reset_L`=0 at a clock edge, every output and all internal state go to 0: `data_out`, `valid_out`, recirculation data, `valid_recirc`, `lane_ptr`, `word_count`. Reset overrides any concurrent `valid_in`.
- **Default each cycle.** `valid_out` and `valid_recirc` clear to 0. Data registers of lanes that receive nothing hold their previous value. The recirculation data register also holds.
- **`valid_in`=1 with `active_lane` nonzero.**
  - Target lane t is `lane_ptr` if `active_lane[lane_ptr]`=1. Otherwise t is the first set bit found searching upward from `lane_ptr`+1 and wrapping modulo `LANES`.
  - Lane t's slice of `data_out` is loaded with `data_in`, and `valid_out[t]` is set to 1.
  - `lane_ptr` becomes the next set bit after t, searching cyclically with the same-cycle mask. If t is the only active lane, `lane_ptr` becomes t.
  - `word_count[t]` increments by 1 and saturates at 2^CNT_W−1; it never wraps.
- **`valid_in`=1 with `active_lane` all zero.** `data_out_Recirc_Retorno` is loaded with `data_in` and `valid_recirc` is set to 1. `lane_ptr` and all counters are unchanged.
- **`valid_in`=0.** No pulses are generated. `lane_ptr` is unchanged, even if the mask changes.
- **Mask changes.** The mask takes effect in the same cycle it is applied. There is no draining and no word loss: each valid word goes to exactly one of the lanes or the recirculation output.
- **Exclusivity.** At most one bit of {`valid_out`, `valid_recirc`} is high in any cycle.

## Timing
- Latency is exactly 1 cycle: a word presented at edge k appears with its valid pulse after edge k+1.
- Throughput is one word per cycle, sustained. There is no backpressure; the downstream must accept every pulse.
- All outputs are registered; no combinational path runs from inputs to outputs.
- `lane_ptr` and `word_count` reflect the word accepted at the previous edge.
- Reset mid-stream: a word presented in the reset cycle is dropped. The first word after reset release targets lane 0 if `active_lane[0]`=1, otherwise the lowest active lane.

## Test plan
- **Two lanes, both active.** LANES=2, mask 2'b11, words 0xA0, 0xB1, 0xC2, 0xD3 on consecutive cycles → lane0 gets 0xA0, lane1 gets 0xB1, lane0 gets 0xC2, lane1 gets 0xD3, each one cycle later. Final counts are 2 and 2; `lane_ptr`=0.
- **Single active lane.** LANES=2, mask 2'b01, three words 1,2,3 → all land on lane0. `valid_out` reads 2'b01 for three cycles; count0=3, count1=0; `lane_ptr` stays 0.
- **No active lane.** Mask 0, word 0xDEADBEEF → `data_out_Recirc_Retorno`=0xDEADBEEF and `valid_recirc`=1 for one cycle. `valid_out`=0, counters unchanged, lane data registers hold.
- **Mask change with skip.** LANES=4, mask 4'b1111, send two words so `lane_ptr`=2. Then set mask 4'b1011 and send 0x55 → 0x55 goes to lane3 and `lane_ptr` becomes 0. The next word 0x66 goes to lane0.
- **Counter saturation.** CNT_W=2, mask 2'b01, five words → count0 reads 1, 2, 3, 3, 3; count1 stays 0.
- **Synchronous reset mid-stream.** Assert `reset_L`=0 for one cycle during continuous traffic → after that edge all outputs are 0 and the word presented in the reset cycle is absent. With mask 2'b11, the next word lands on lane0.
